// File: rtl/mem_port_arbiter_if.sv
// Port-A bus between two requesters, the arbiter and the image memory.
// slave = arbiter side, master = requesters plus memory side.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 64
);
   logic              req0, lock0, we0;
   logic [ADDR_W-1:0] addr0;
   logic [DATA_W-1:0] wdata0;
   logic              gnt0, rvalid0;
   logic [DATA_W-1:0] rdata0;

   logic              req1, lock1, we1;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata1;
   logic              gnt1, rvalid1;
   logic [DATA_W-1:0] rdata1;

   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] inputData;
   logic              writeEnable;
   logic [DATA_W-1:0] out;

   modport slave (
      input  req0, lock0, we0, addr0, wdata0,
      output gnt0, rvalid0, rdata0,
      input  req1, lock1, we1, addr1, wdata1,
      output gnt1, rvalid1, rdata1,
      output address, inputData, writeEnable,
      input  out
   );

   modport master (
      output req0, lock0, we0, addr0, wdata0,
      input  gnt0, rvalid0, rdata0,
      output req1, lock1, we1, addr1, wdata1,
      input  gnt1, rvalid1, rdata1,
      input  address, inputData, writeEnable,
      output out
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for image-memory port A with locked bursts and read return routing.
// MEM_ARB_FIXED_PRIO_EN: requester 0 has fixed priority instead of round-robin.
module mem_port_arbiter #(
   parameter int ADDR_W       = 16,
   parameter int DATA_W       = 64,
   parameter int READ_LATENCY = 1
) (
   input logic              clk_FPGA,
   input logic              rst,
   mem_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_REQ0 = 2'd1,
      OWN_REQ1 = 2'd2
   } owner_e;

   owner_e owner_q, owner_d, owner_eff;
`ifndef MEM_ARB_FIXED_PRIO_EN
   logic last_q, last_d;
`endif

   logic gnt0, gnt1;
   logic [ADDR_W-1:0] addr_mux;
   logic [DATA_W-1:0] wdata_mux;
   logic              we_mux;

   logic [READ_LATENCY-1:0] vld_pipe_q;
   logic [READ_LATENCY-1:0] id_pipe_q;

   always_ff @(posedge clk_FPGA) begin
      if (rst) begin
         owner_q <= OWN_NONE;
`ifndef MEM_ARB_FIXED_PRIO_EN
         last_q  <= 1'b1;
`endif
      end else begin
         owner_q <= owner_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
         last_q  <= last_d;
`endif
      end
   end

   always_comb begin
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      owner_eff = owner_q;
`ifndef MEM_ARB_FIXED_PRIO_EN
      last_d    = last_q;
`endif
      // A lock holder that stops requesting releases the port in the same cycle.
      if ((owner_q == OWN_REQ0 && !bus.req0) || (owner_q == OWN_REQ1 && !bus.req1))
         owner_eff = OWN_NONE;
      owner_d = owner_eff;

      if (!rst) begin
         if (owner_eff == OWN_REQ0) begin
            gnt0 = 1'b1;
         end else if (owner_eff == OWN_REQ1) begin
            gnt1 = 1'b1;
         end else begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            gnt0 = bus.req0;
            gnt1 = bus.req1 && !bus.req0;
`else
            if (bus.req0 && bus.req1) begin
               gnt0 = last_q;
               gnt1 = !last_q;
            end else begin
               gnt0 = bus.req0;
               gnt1 = bus.req1;
            end
`endif
         end
      end

      if (gnt0) begin
         owner_d = bus.lock0 ? OWN_REQ0 : OWN_NONE;
`ifndef MEM_ARB_FIXED_PRIO_EN
         last_d  = 1'b0;
`endif
      end else if (gnt1) begin
         owner_d = bus.lock1 ? OWN_REQ1 : OWN_NONE;
`ifndef MEM_ARB_FIXED_PRIO_EN
         last_d  = 1'b1;
`endif
      end
   end

   always_comb begin
      addr_mux  = '0;
      wdata_mux = '0;
      we_mux    = 1'b0;
      if (gnt0) begin
         addr_mux  = bus.addr0;
         wdata_mux = bus.wdata0;
         we_mux    = bus.we0;
      end else if (gnt1) begin
         addr_mux  = bus.addr1;
         wdata_mux = bus.wdata1;
         we_mux    = bus.we1;
      end
   end

   assign bus.gnt0        = gnt0;
   assign bus.gnt1        = gnt1;
   assign bus.address     = addr_mux;
   assign bus.inputData   = wdata_mux;
   assign bus.writeEnable = we_mux;

   // Each accepted access pushes {valid, id}; writes push an empty slot.
   always_ff @(posedge clk_FPGA) begin
      if (rst) begin
         vld_pipe_q <= '0;
         id_pipe_q  <= '0;
      end else begin
         vld_pipe_q[0] <= (gnt0 || gnt1) && !we_mux;
         id_pipe_q[0]  <= gnt1;
         for (int i = 1; i < READ_LATENCY; i++) begin
            vld_pipe_q[i] <= vld_pipe_q[i-1];
            id_pipe_q[i]  <= id_pipe_q[i-1];
         end
      end
   end

   // Gating with rst drops returns of reads that a reset is abandoning.
   assign bus.rvalid0 = !rst && vld_pipe_q[READ_LATENCY-1] && !id_pipe_q[READ_LATENCY-1];
   assign bus.rvalid1 = !rst && vld_pipe_q[READ_LATENCY-1] &&  id_pipe_q[READ_LATENCY-1];
   assign bus.rdata0  = bus.out;
   assign bus.rdata1  = bus.out;

   a_gnt_onehot : assert property (@(posedge clk_FPGA) !(gnt0 && gnt1));
   a_gnt0_req   : assert property (@(posedge clk_FPGA) gnt0 |-> bus.req0);
   a_gnt1_req   : assert property (@(posedge clk_FPGA) gnt1 |-> bus.req1);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;
   localparam int LAT = 1;

   typedef struct {
      int          id;
      logic [63:0] data;
      int          due;
   } rd_t;

   logic clk;
   logic rst;
   mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(64)) mif ();

   mem_port_arbiter #(.ADDR_W(16), .DATA_W(64), .READ_LATENCY(LAT)) dut (
      .clk_FPGA (clk),
      .rst      (rst),
      .bus      (mif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Physical memory: write-first port A, LAT-cycle registered read.
   logic [63:0] pmem [0:65535];
   logic [63:0] rd_pipe [LAT];
   always @(posedge clk) begin
      if (mif.writeEnable) pmem[mif.address] = mif.inputData;
      rd_pipe[0] <= pmem[mif.address];
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign mif.out = rd_pipe[LAT-1];

   // Reference model state
   logic [63:0] ref_mem [0:65535];
   int  last_id, owner, cyc, g_prev;
   rd_t expq[$];
   int  n_cmp, n_err;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic int model_arb();
      int o;
      o = owner;
      if (rst) return -1;
      if (o == 0 && mif.req0) return 0;
      if (o == 1 && mif.req1) return 1;
`ifdef MEM_ARB_FIXED_PRIO_EN
      if (mif.req0) return 0;
      if (mif.req1) return 1;
`else
      if (mif.req0 && mif.req1) return (last_id == 0) ? 1 : 0;
      if (mif.req0) return 0;
      if (mif.req1) return 1;
`endif
      return -1;
   endfunction

   task automatic step();
      int g;
      bit rv0, rv1, we;
      logic [63:0] rd, wd;
      logic [15:0] ad;
      rd_t e;
      g = model_arb();
      rv0 = 0; rv1 = 0; rd = '0;
      if (expq.size() > 0 && expq[0].due == cyc) begin
         e = expq.pop_front();
         if (!rst) begin
            if (e.id == 0) rv0 = 1; else rv1 = 1;
            rd = e.data;
         end
      end
      ad = (g == 0) ? mif.addr0 : (g == 1) ? mif.addr1 : 16'h0;
      wd = (g == 0) ? mif.wdata0 : (g == 1) ? mif.wdata1 : 64'h0;
      we = (g == 0) ? mif.we0 : (g == 1) ? mif.we1 : 1'b0;
      #1;
      chk("gnt0", 64'(mif.gnt0), 64'(g == 0));
      chk("gnt1", 64'(mif.gnt1), 64'(g == 1));
      chk("address", 64'(mif.address), 64'(ad));
      chk("writeEnable", 64'(mif.writeEnable), 64'(we));
      chk("inputData", mif.inputData, wd);
      chk("rvalid0", 64'(mif.rvalid0), 64'(rv0));
      chk("rvalid1", 64'(mif.rvalid1), 64'(rv1));
      if (rv0) chk("rdata0", mif.rdata0, rd);
      if (rv1) chk("rdata1", mif.rdata1, rd);
      @(posedge clk);
      cyc++;
      if (rst) begin
         last_id = 1;
         owner   = -1;
         expq.delete();
      end else if (g >= 0) begin
         last_id = g;
         owner   = ((g == 0) ? mif.lock0 : mif.lock1) ? g : -1;
         if (we) ref_mem[ad] = wd;
         else begin
            e.id = g; e.data = ref_mem[ad]; e.due = cyc + LAT - 1;
            expq.push_back(e);
         end
      end else if ((owner == 0 && !mif.req0) || (owner == 1 && !mif.req1)) begin
         owner = -1;
      end
      g_prev = g;
      @(negedge clk);
   endtask

   task automatic idle();
      mif.req0 = 0; mif.lock0 = 0; mif.we0 = 0; mif.addr0 = '0; mif.wdata0 = '0;
      mif.req1 = 0; mif.lock1 = 0; mif.we1 = 0; mif.addr1 = '0; mif.wdata1 = '0;
   endtask

   task automatic do_reset();
      rst = 1; idle();
      step(); step();
      rst = 0;
   endtask

   task automatic rd0(input logic [15:0] a);
      mif.req0 = 1; mif.we0 = 0; mif.addr0 = a;
   endtask
   task automatic rd1(input logic [15:0] a);
      mif.req1 = 1; mif.we1 = 0; mif.addr1 = a;
   endtask

   initial begin
      n_cmp = 0; n_err = 0; cyc = 0; g_prev = -1;
      last_id = 1; owner = -1;
      for (int i = 0; i < 65536; i++) begin
         pmem[i]    = {16'hA5A5, 16'(i), ~16'(i), 16'(i) ^ 16'h3C3C};
         ref_mem[i] = pmem[i];
      end
      pmem[16'h0010]    = 64'h0123_4567_89AB_CDEF;
      ref_mem[16'h0010] = 64'h0123_4567_89AB_CDEF;
      rst = 1; idle();
      @(negedge clk);
      do_reset();

      // 1: single read
      rd0(16'h0010);
      step();
      idle();
      #1;
      chk("t1_rvalid0", 64'(mif.rvalid0), 64'd1);
      chk("t1_rdata0", mif.rdata0, 64'h0123_4567_89AB_CDEF);
      chk("t1_rvalid1", 64'(mif.rvalid1), 64'd0);
      step();

      // 2: round-robin on contention
      do_reset();
      for (int i = 0; i < 6; i++) begin
         rd0(16'h0020 + 16'(i)); rd1(16'h0030 + 16'(i));
         step();
      end
      idle(); step(); step();

      // 3: locked write burst by requester 1 while requester 0 waits
      for (int i = 0; i < 4; i++) begin
         mif.req1 = 1; mif.we1 = 1; mif.addr1 = 16'h0100 + 16'(i);
         mif.wdata1 = 64'hB000_0000_0000_0000 + 64'(i);
         mif.lock1 = (i < 3);
         if (i > 0) rd0(16'h0100);
         step();
      end
      idle(); rd0(16'h0100);
      step();
      idle(); rd0(16'h0103);
      step();
      idle(); step();

      // 4: write then read the same word by the other requester
      mif.req0 = 1; mif.we0 = 1; mif.addr0 = 16'h0200; mif.wdata0 = 64'hDEAD_BEEF_0000_0001;
      step();
      idle(); rd1(16'h0200);
      step();
      idle();
      #1;
      chk("t4_rvalid1", 64'(mif.rvalid1), 64'd1);
      chk("t4_rdata1", mif.rdata1, 64'hDEAD_BEEF_0000_0001);
      step();

      // 5: reset right after an accepted read
      rd0(16'h0010);
      step();
      idle(); rst = 1;
      step(); step();
      rst = 0;
      rd0(16'h0040); rd1(16'h0041);
      #1;
      chk("t5_first_gnt0", 64'(mif.gnt0), 64'd1);
      step();
      idle(); step(); step();

`ifdef MEM_ARB_FIXED_PRIO_EN
      // 6: fixed priority
      for (int i = 0; i < 5; i++) begin
         rd0(16'h0050 + 16'(i)); rd1(16'h0060);
         step();
      end
      mif.req0 = 0;
      step();
      idle(); step(); step();
`endif

      // Random traffic with occasional resets
      for (int c = 0; c < 500; c++) begin
         rst = ($urandom_range(0, 59) == 0);
         if (!(mif.req0 && g_prev != 0)) begin
            mif.req0   = ($urandom_range(0, 9) < 7);
            mif.we0    = ($urandom_range(0, 9) < 4);
            mif.addr0  = 16'h0200 + 16'($urandom_range(0, 7));
            mif.wdata0 = {$urandom, $urandom};
         end
         if (!(mif.req1 && g_prev != 1)) begin
            mif.req1   = ($urandom_range(0, 9) < 7);
            mif.we1    = ($urandom_range(0, 9) < 4);
            mif.addr1  = 16'h0200 + 16'($urandom_range(0, 7));
            mif.wdata1 = {$urandom, $urandom};
         end
         mif.lock0 = ($urandom_range(0, 9) < 3);
         mif.lock1 = ($urandom_range(0, 9) < 3);
         step();
      end
      rst = 0; idle();
      for (int i = 0; i < LAT + 1; i++) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares port A of the dual-port image memory (16-bit word address, 64-bit data) between two requesters, such as an image-processing core and a frame loader. Port B stays with the VGA image reader. The arbiter picks one requester per cycle and muxes its address, write data and write enable onto the memory port. It routes read data back to the issuing requester after the fixed memory read latency. It supports locked bursts so one requester can hold the port across consecutive accesses.

Parameters:
ADDR_W, 16, memory word-address width
DATA_W, 64, memory data width
READ_LATENCY, 1, clock cycles from accepted read to valid memory out (1..4)

Ports:
clk_FPGA  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
req0  in  1  requester 0 access request
lock0  in  1  requester 0 wants to keep the port after this access
we0  in  1  requester 0 write (1) / read (0)
addr0  in  ADDR_W  requester 0 address
wdata0  in  DATA_W  requester 0 write data
gnt0  out  1  requester 0 access accepted this cycle
rvalid0  out  1  rdata0 valid (one cycle per read)
rdata0  out  DATA_W  read data to requester 0
req1, lock1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as requester 0, for requester 1
address  out  ADDR_W  to memory port A address
inputData  out  DATA_W  to memory port A write data
writeEnable  out  1  to memory port A write enable
out  in  DATA_W  memory port A read data

Behaviour:
- Clock and reset: one clock, clk_FPGA. rst is synchronous and active-high.
- Handshake: a transfer occurs on a rising edge where reqN=1 and gntN=1.
  - gntN is combinational from the current requests and registered arbiter state.
  - The requester holds addr, we and wdata stable while reqN=1 and gntN=0.
  - The requester may change them in the cycle after a transfer.
- At most one of gnt0/gnt1 is high in any cycle. gntN never rises without reqN.
- Memory mux:
  - address, inputData and writeEnable equal the granted requester's signals in the same cycle.
  - With no grant: writeEnable=0, address=0, inputData=0.
- Arbitration state is a registered pointer `last` (last granted id) plus a registered `owner` (lock holder, or none).
  - If owner=N and reqN=1: grant N only.
  - If owner=N and reqN=0: clear owner that cycle and arbitrate normally.
  - Otherwise, if only one request is active, grant it.
  - If both requests are active, grant the id that is not `last` (round-robin).
- State updates on a transfer by N:
  - `last` <= N.
  - owner <= N if lockN=1; otherwise owner <= none.
- Read return:
  - A shift register READ_LATENCY deep carries {valid, id} for each accepted read. Writes insert valid=0.
  - READ_LATENCY cycles after a read transfer by N, rvalidN=1 for exactly one cycle.
  - rdata0 and rdata1 both carry `out` continuously. They are meaningful only when the matching rvalid is high.
  - Back-to-back reads from either requester are supported, one per cycle, with full throughput. The return order matches the issue order.
- A write followed by a read of the same address in the next cycle returns the new data. The memory is write-first within port A; the arbiter adds no forwarding.
- Reset (rst=1 at an edge):
  - `last` <= 1, so requester 0 wins the first contention.
  - owner <= none.
  - Return pipeline cleared.
  - While rst=1: gnt0=gnt1=0, writeEnable=0, rvalid0=rvalid1=0.
- Reset mid-operation: reads accepted before reset never produce rvalid. A locked burst is abandoned.
- Read/write pairing: a requester asserting we=1 receives no rvalid for that access.
- Simultaneous events: a transfer and a lock release in the same cycle are legal. Lock drops to none after that access.

Optional Feature:
MEM_ARB_FIXED_PRIO_EN
- Defined: requester 0 always wins when both request, except when requester 1 holds an active lock.
  - `last` is not used.
  - Requester 1 is granted only when req0=0 or owner=1.
- Not defined: round-robin as above.

Test Plan:
1. Reset, then req0 read at addr0=0x0010 with memory word 0x0123_4567_89AB_CDEF -> gnt0=1 that cycle; address=0x0010, writeEnable=0; rvalid0=1 one cycle later with rdata0=0x0123456789ABCDEF; rvalid1 stays 0.
2. req0 and req1 both held high with reads for 6 cycles (no lock) -> grants alternate 0,1,0,1,0,1; six rvalids return in the same order.
3. req1 burst of 4 writes with lock1=1 on the first 3 and 0 on the last, while req0 is held -> gnt1 for 4 consecutive cycles, then gnt0; addresses 0x0100..0x0103 written.
4. Write 0xDEAD_BEEF_0000_0001 to 0x0200 by req0, then read 0x0200 by req1 the next cycle -> rvalid1 with 0xDEADBEEF00000001.
5. req0 read accepted, rst=1 on the following edge -> no rvalid0 ever; after reset, with both requesting, gnt0 wins first.
6. With MEM_ARB_FIXED_PRIO_EN defined, both requesting continuously for 5 cycles -> gnt0 on all 5, gnt1=0; with req0 dropped -> gnt1=1 next cycle.
